// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that lets three requesters share one UART transmitter.
// A granted requester's byte and baud code are captured at grant time; the
// shared baud controller is retuned (and given time to settle) only when the
// captured code differs from the one currently driven.
module uart_tx_scheduler #(
    parameter int SETTLE_TICKS = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_data,
    input  logic [8:0]  req_baud,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        err,
    output logic [2:0]  baud_select,
    input  logic        sample_ENABLE,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    output logic        tx_en,
    input  logic        tx_busy
);

    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONFIG    = 3'd1,
        LOAD      = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      owner_r;
    logic [1:0]      last_grant_r;
    logic [1:0]      winner_s;
    logic [7:0]      byte_r;
    logic [7:0]      win_byte_s;
    logic [2:0]      baud_r;
    logic [2:0]      win_baud_s;
    logic [2:0]      win_onehot_s;
    logic            settle_active_r;
    logic [SW-1:0]   settle_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic            timeout_s;
    logic [2:0]      grant_r;
    logic [2:0]      done_r;
    logic            err_r;
    logic [2:0]      baud_select_r;
    logic [7:0]      tx_data_r;
    logic            tx_wr_r;
    logic            tx_en_r;

    assign grant       = grant_r;
    assign done        = done_r;
    assign err         = err_r;
    assign baud_select = baud_select_r;
    assign tx_data     = tx_data_r;
    assign tx_wr       = tx_wr_r;
    assign tx_en       = tx_en_r;

    // Round-robin pick: search starts at the requester after the last owner.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p;
        p = 2'd0;
        case (last)
            2'd0:    begin if (r[1]) p = 2'd1; else if (r[2]) p = 2'd2; else p = 2'd0; end
            2'd1:    begin if (r[2]) p = 2'd2; else if (r[0]) p = 2'd0; else p = 2'd1; end
            default: begin if (r[0]) p = 2'd0; else if (r[1]) p = 2'd1; else p = 2'd2; end
        endcase
        return p;
    endfunction

    // Arbitration winner and the byte/baud/one-hot belonging to it.
    always_comb begin
        winner_s = rr_pick(req, last_grant_r);
        case (winner_s)
            2'd0: begin
                win_byte_s   = req_data[7:0];
                win_baud_s   = req_baud[2:0];
                win_onehot_s = 3'b001;
            end
            2'd1: begin
                win_byte_s   = req_data[15:8];
                win_baud_s   = req_baud[5:3];
                win_onehot_s = 3'b010;
            end
            default: begin
                win_byte_s   = req_data[23:16];
                win_baud_s   = req_baud[8:6];
                win_onehot_s = 3'b100;
            end
        endcase
    end

    // Next-state logic; unreachable encodings fall back to IDLE.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 3'b000) state_s = CONFIG;
                else               state_s = IDLE;
            end
            CONFIG: begin
                if (settle_active_r) begin
                    if (sample_ENABLE && (settle_cnt_r == SETTLE_LAST)) state_s = LOAD;
                    else                                                 state_s = CONFIG;
                end else if (baud_r == baud_select_r) begin
                    state_s = LOAD;
                end else begin
                    state_s = CONFIG;
                end
            end
            LOAD: state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (tmo_cnt_r == TIMEOUT_LAST) begin
                    state_s   = DONE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_s = DONE;
                else          state_s = WAIT_DONE;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Transfer context: captured request, baud retune/settle counter, busy timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r         <= 2'd0;
            last_grant_r    <= 2'd2;
            byte_r          <= 8'h00;
            baud_r          <= 3'b000;
            baud_select_r   <= 3'b000;
            settle_active_r <= 1'b0;
            settle_cnt_r    <= {SW{1'b0}};
            tmo_cnt_r       <= {TW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != 3'b000) begin
                        owner_r         <= winner_s;
                        byte_r          <= win_byte_s;
                        baud_r          <= win_baud_s;
                        settle_active_r <= 1'b0;
                        settle_cnt_r    <= {SW{1'b0}};
                    end
                end
                CONFIG: begin
                    // The tick coincident with the retune is deliberately not counted.
                    if (settle_active_r) begin
                        if (sample_ENABLE && (state_s == CONFIG))
                            settle_cnt_r <= settle_cnt_r + SW'(1);
                    end else if (baud_r != baud_select_r) begin
                        baud_select_r   <= baud_r;
                        settle_active_r <= 1'b1;
                        settle_cnt_r    <= {SW{1'b0}};
                    end
                end
                LOAD: tmo_cnt_r <= TW'(1);
                WAIT_BUSY: begin
                    if (state_s == WAIT_BUSY) tmo_cnt_r <= tmo_cnt_r + TW'(1);
                end
                DONE: begin
                    last_grant_r    <= owner_r;
                    settle_active_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs, aligned with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r   <= 3'b000;
            done_r    <= 3'b000;
            err_r     <= 1'b0;
            tx_wr_r   <= 1'b0;
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
        end else begin
            tx_wr_r <= (state_s == LOAD);
            tx_en_r <= (state_s == LOAD) || (state_s == WAIT_BUSY) || (state_s == WAIT_DONE);
            err_r   <= timeout_s;
            done_r  <= (state_s == DONE) ? grant_r : 3'b000;
            if (state_s == LOAD) tx_data_r <= byte_r;
            if (state_s == IDLE)      grant_r <= 3'b000;
            else if (state_r == IDLE) grant_r <= win_onehot_s;
        end
    end

endmodule
